svm_channel_scheduler: RTL and testbench

- Time-shares one space_vector_modulator instance between NUM_CH motor channels.
- Each channel presents alpha/beta voltage requests over valid/ready; the scheduler arbitrates round-robin and issues one request at a time to the modulator.
- Returns the u/v/w duty triple to the owning channel's duty register.
- Sits between the per-wheel current controllers and the PWM generators.

---
 rtl/svm_channel_scheduler.sv | 172 +++++++++++++++++
 tb/tb_svm_channel_scheduler.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/svm_channel_scheduler.sv
`default_nettype none
// ============================================================================
// svm_channel_scheduler : round-robin sharing of one space-vector modulator
//                         between NUM_CH channels, with duty write-back
// Revision: 1.0
// ============================================================================
module svm_channel_scheduler #(
  parameter int NUM_CH         = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  err_clear,
  input  logic [32*NUM_CH-1:0]  ch_data,
  input  logic [NUM_CH-1:0]     ch_valid,
  output logic [NUM_CH-1:0]     ch_ready,
  output logic [31:0]           svm_in_data,
  output logic                  svm_in_valid,
  input  logic                  svm_in_ready,
  input  logic [47:0]           svm_out_data,
  input  logic                  svm_out_valid,
  output logic [48*NUM_CH-1:0]  duty_data,
  output logic [NUM_CH-1:0]     duty_update,
  output logic                  busy,
  output logic                  timeout_err
);

  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [PTR_W-1:0] PTR_RST  = PTR_W'(NUM_CH - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   grant_q, grant_d;
  logic [31:0]        hold_q, hold_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [47:0]        duty_q [NUM_CH];
  logic [47:0]        duty_d [NUM_CH];
  logic [NUM_CH-1:0]  duty_update_q, duty_update_d;
  logic               timeout_err_q, timeout_err_d;

  logic [31:0]        ch_data_arr [NUM_CH];
  logic               arb_found;
  logic [PTR_W-1:0]   arb_idx;
  logic               handshake;
  logic [NUM_CH-1:0]  ready_w;

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
      assign ch_data_arr[i]          = ch_data[32*i +: 32];
      assign duty_data[48*i +: 48]   = duty_q[i];
    end
  endgenerate

  // Search starts just after the last served channel, so it ends up lowest priority.
  always_comb begin
    int               cand;
    logic [PTR_W-1:0] cidx;
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = 0;
    cidx      = '0;
    for (int off = 1; off <= NUM_CH; off++) begin
      cand = (int'(ptr_q) + off) % NUM_CH;
      cidx = PTR_W'(cand);
      if (!arb_found && ch_valid[cidx]) begin
        arb_found = 1'b1;
        arb_idx   = cidx;
      end
    end
  end

  assign handshake = (state_q == S_IDLE) && enable && arb_found;

  always_comb begin
    ready_w = '0;
    if (handshake) begin
      ready_w[arb_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    grant_d       = grant_q;
    hold_d        = hold_q;
    timer_d       = timer_q;
    duty_d        = duty_q;
    duty_update_d = '0;
    timeout_err_d = timeout_err_q;

    if (err_clear) begin
      timeout_err_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (handshake) begin
          hold_d  = ch_data_arr[arb_idx];
          grant_d = arb_idx;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (svm_in_ready) begin
          timer_d = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        timer_d = timer_q + 1'b1;
        // A result arriving on the timeout cycle is still accepted.
        if (svm_out_valid) begin
          duty_d[grant_q]        = svm_out_data;
          duty_update_d[grant_q] = 1'b1;
          ptr_d                  = grant_q;
          state_d                = S_IDLE;
        end else if (timer_q == TMR_LAST) begin
          timeout_err_d = 1'b1;
          ptr_d         = grant_q;
          state_d       = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      ptr_q         <= PTR_RST;
      grant_q       <= '0;
      hold_q        <= '0;
      timer_q       <= '0;
      duty_update_q <= '0;
      timeout_err_q <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        duty_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      grant_q       <= grant_d;
      hold_q        <= hold_d;
      timer_q       <= timer_d;
      duty_update_q <= duty_update_d;
      timeout_err_q <= timeout_err_d;
      for (int i = 0; i < NUM_CH; i++) begin
        duty_q[i] <= duty_d[i];
      end
    end
  end

  assign ch_ready     = ready_w;
  assign svm_in_valid = (state_q == S_ISSUE);
  assign svm_in_data  = hold_q;
  assign duty_update  = duty_update_q;
  assign busy         = (state_q != S_IDLE);
  assign timeout_err  = timeout_err_q;

endmodule
`default_nettype wire

// File: tb/tb_svm_channel_scheduler.sv
`default_nettype none
// Directed bench for svm_channel_scheduler; the bench plays the modulator side.
module tb_svm_channel_scheduler;

  localparam int NUM_CH         = 4;
  localparam int TIMEOUT_CYCLES = 64;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  enable;
  logic                  err_clear;
  logic [32*NUM_CH-1:0]  ch_data;
  logic [NUM_CH-1:0]     ch_valid;
  logic [NUM_CH-1:0]     ch_ready;
  logic [31:0]           svm_in_data;
  logic                  svm_in_valid;
  logic                  svm_in_ready;
  logic [47:0]           svm_out_data;
  logic                  svm_out_valid;
  logic [48*NUM_CH-1:0]  duty_data;
  logic [NUM_CH-1:0]     duty_update;
  logic                  busy;
  logic                  timeout_err;

  int errors = 0;
  int checks = 0;
  int xfers  = 0;

  svm_channel_scheduler #(
    .NUM_CH         (NUM_CH),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .err_clear     (err_clear),
    .ch_data       (ch_data),
    .ch_valid      (ch_valid),
    .ch_ready      (ch_ready),
    .svm_in_data   (svm_in_data),
    .svm_in_valid  (svm_in_valid),
    .svm_in_ready  (svm_in_ready),
    .svm_out_data  (svm_out_data),
    .svm_out_valid (svm_out_valid),
    .duty_data     (duty_data),
    .duty_update   (duty_update),
    .busy          (busy),
    .timeout_err   (timeout_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (svm_in_valid && svm_in_ready) xfers <= xfers + 1;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [47:0] duty_of(input int g);
    return duty_data[g*48 +: 48];
  endfunction

  // One full transaction for channel g with all channels requesting.
  task automatic serve(input int g, input logic [47:0] res);
    logic [3:0] onehot;
    onehot = 4'b0001 << g;
    #1;
    check("rr_ready", 64'(ch_ready), 64'(onehot));
    tick();
    check("rr_in_valid", 64'(svm_in_valid), 64'h1);
    check("rr_in_data", 64'(svm_in_data), 64'({16'(g), 16'h1000 + 16'(g)}));
    tick();
    check("rr_in_valid_low", 64'(svm_in_valid), 64'h0);
    svm_out_data  = res;
    svm_out_valid = 1'b1;
    tick();
    svm_out_valid = 1'b0;
    check("rr_update", 64'(duty_update), 64'(onehot));
    check("rr_duty", 64'(duty_of(g)), 64'(res));
  endtask

  initial begin
    int order [5];
    order = '{0, 1, 2, 3, 0};

    reset         = 1'b0;
    enable        = 1'b1;
    err_clear     = 1'b0;
    ch_data       = '0;
    ch_valid      = '0;
    svm_in_ready  = 1'b1;
    svm_out_data  = '0;
    svm_out_valid = 1'b0;

    // Reset state
    tick(); tick(); tick();
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_ready", 64'(ch_ready), 64'h0);
    check("rst_in_valid", 64'(svm_in_valid), 64'h0);
    check("rst_in_data", 64'(svm_in_data), 64'h0);
    check("rst_duty", 64'(|duty_data), 64'h0);
    check("rst_update", 64'(duty_update), 64'h0);
    check("rst_err", 64'(timeout_err), 64'h0);
    reset = 1'b1;
    tick();

    // Round-robin from reset pointer: 0,1,2,3,0
    for (int i = 0; i < NUM_CH; i++) ch_data[32*i +: 32] = {16'(i), 16'h1000 + 16'(i)};
    ch_valid = 4'hF;
    for (int k = 0; k < 5; k++)
      serve(order[k], {16'h0100 + 16'(k), 16'h0200 + 16'(k), 16'h0300 + 16'(k)});
    ch_valid = 4'h0;
    tick();
    check("rr_idle_update", 64'(duty_update), 64'h0);
    check("rr_idle_busy", 64'(busy), 64'h0);

    // Single request on channel 2, result after 5 cycles
    ch_data[64 +: 32] = {16'd2960, 16'd0};
    ch_valid = 4'b0100;
    #1;
    check("single_ready", 64'(ch_ready), 64'h4);
    tick();
    ch_valid = 4'b0000;
    #1;
    check("single_ready_low", 64'(ch_ready), 64'h0);
    check("single_in_valid", 64'(svm_in_valid), 64'h1);
    check("single_in_data", 64'(svm_in_data), 64'h0B90_0000);
    check("single_busy", 64'(busy), 64'h1);
    tick();
    check("single_in_valid_low", 64'(svm_in_valid), 64'h0);
    tick(); tick(); tick(); tick();
    check("single_no_early_update", 64'(duty_update), 64'h0);
    svm_out_data  = {16'd100, 16'd200, 16'd300};
    svm_out_valid = 1'b1;
    tick();
    svm_out_valid = 1'b0;
    check("single_update", 64'(duty_update), 64'h4);
    check("single_duty", 64'(duty_of(2)), 64'h0064_00C8_012C);
    check("single_busy_low", 64'(busy), 64'h0);
    tick();
    check("single_update_once", 64'(duty_update), 64'h0);

    // Stray result while idle
    svm_out_data  = 48'hDEAD_BEEF_CAFE;
    svm_out_valid = 1'b1;
    tick();
    svm_out_valid = 1'b0;
    check("stray_update", 64'(duty_update), 64'h0);
    check("stray_duty2", 64'(duty_of(2)), 64'h0064_00C8_012C);
    check("stray_duty0", 64'(duty_of(0)), 64'h0104_0204_0304);
    check("stray_busy", 64'(busy), 64'h0);

    // Modulator backpressure for 7 cycles
    xfers = 0;
    ch_data[32 +: 32] = 32'h1234_5678;
    ch_valid     = 4'b0010;
    svm_in_ready = 1'b0;
    #1;
    check("bp_ready", 64'(ch_ready), 64'h2);
    tick();
    ch_valid = 4'b0000;
    for (int c = 0; c < 7; c++) begin
      check("bp_in_valid", 64'(svm_in_valid), 64'h1);
      check("bp_in_data", 64'(svm_in_data), 64'h1234_5678);
      tick();
    end
    check("bp_in_valid_end", 64'(svm_in_valid), 64'h1);
    svm_in_ready = 1'b1;
    tick();
    check("bp_in_valid_low", 64'(svm_in_valid), 64'h0);
    svm_out_data  = 48'h0011_0022_0033;
    svm_out_valid = 1'b1;
    tick();
    svm_out_valid = 1'b0;
    check("bp_update", 64'(duty_update), 64'h2);
    check("bp_duty", 64'(duty_of(1)), 64'h0011_0022_0033);
    check("bp_xfers", 64'(xfers), 64'h1);

    // Timeout: ptr=1, so channel 2 goes first, channel 0 next
    ch_valid = 4'b0101;
    #1;
    check("to_ready", 64'(ch_ready), 64'h4);
    tick();
    tick();
    for (int k = 1; k <= 63; k++) begin
      check("to_err_early", 64'(timeout_err), 64'h0);
      check("to_busy", 64'(busy), 64'h1);
      tick();
    end
    check("to_err_63", 64'(timeout_err), 64'h0);
    check("to_ready_wait", 64'(ch_ready), 64'h0);
    tick();
    check("to_err_64", 64'(timeout_err), 64'h1);
    check("to_update", 64'(duty_update), 64'h0);
    check("to_busy_low", 64'(busy), 64'h0);
    check("to_duty_kept", 64'(duty_of(2)), 64'h0064_00C8_012C);
    #1;
    check("to_next_grant", 64'(ch_ready), 64'h1);
    ch_valid = 4'b0000;
    tick();
    check("to_err_sticky", 64'(timeout_err), 64'h1);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    check("to_err_clear", 64'(timeout_err), 64'h0);

    // Enable low blocks grants
    enable   = 1'b0;
    ch_valid = 4'hF;
    #1;
    check("en_ready", 64'(ch_ready), 64'h0);
    tick();
    check("en_busy", 64'(busy), 64'h0);
    check("en_ready2", 64'(ch_ready), 64'h0);

    // Re-enable: ptr=2 after the timeout, so channel 3 wins; reset during WAIT
    enable = 1'b1;
    #1;
    check("en_grant", 64'(ch_ready), 64'h8);
    tick();
    ch_valid = 4'h0;
    tick();
    tick();
    check("rw_busy", 64'(busy), 64'h1);
    reset = 1'b0;
    #1;
    check("rw_busy_low", 64'(busy), 64'h0);
    check("rw_duty", 64'(|duty_data), 64'h0);
    check("rw_duty1", 64'(duty_of(1)), 64'h0);
    check("rw_update", 64'(duty_update), 64'h0);
    svm_out_data  = 48'h0AAA_0BBB_0CCC;
    svm_out_valid = 1'b1;
    tick();
    svm_out_valid = 1'b0;
    reset = 1'b1;
    tick();
    check("rw_post_update", 64'(duty_update), 64'h0);
    tick();
    check("rw_post_update2", 64'(duty_update), 64'h0);
    check("rw_post_duty", 64'(|duty_data), 64'h0);
    check("rw_post_busy", 64'(busy), 64'h0);
    check("rw_post_in_valid", 64'(svm_in_valid), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
